frame_writer: RTL

//  Output end of the 3x3 filter path: sinks the filtered pixel stream (one pixel per valid
//  3x3 window from the pixel memory/window reader) into an IMG_W x IMG_H frame buffer.

---
 rtl/img_pkg.sv | 14 +
 rtl/frame_writer_if.sv | 24 ++
 rtl/frame_ram.sv | 29 ++
 rtl/frame_writer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared constants and enums for the 3x3 filter output path.
package img_pkg;
    localparam int IMG_W      = 86;
    localparam int IMG_H      = 102;
    localparam int ADDR_W     = 14;
    localparam int FRAME_PIX  = IMG_W * IMG_H;
    localparam int INT_PIX    = (IMG_W - 2) * (IMG_H - 2);
    localparam int BORDER_PIX = 2 * IMG_W + 2 * (IMG_H - 2);

    typedef enum logic [1:0] {IDLE, ACCEPT, BORDER, DONE} state_t;

    // Border sequencer phases: full top row, full bottom row, then left/right pairs per row.
    typedef enum logic [1:0] {B_TOP, B_BOT, B_LEFT, B_RIGHT} border_ph_t;
endpackage

// File: rtl/frame_writer_if.sv
// Pixel stream, control and readback signals of the frame writer.
interface frame_writer_if #(
    parameter int ADDR_W = img_pkg::ADDR_W
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_pixel;
    logic              in_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wr_count;

    modport master (
        output start, in_valid, in_pixel, rd_addr,
        input  in_ready, rd_data, busy, done, wr_count
    );

    modport slave (
        input  start, in_valid, in_pixel, rd_addr,
        output in_ready, rd_data, busy, done, wr_count
    );
endinterface

// File: rtl/frame_ram.sv
// Frame buffer: one write port, one registered read port; reads past the frame return zero.
module frame_ram #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 8772
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read samples the array before this edge's write lands, so a collision returns old data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                    r_rdata <= 8'h00;
        else if (int'(i_raddr) < DEPTH)  r_rdata <= r_mem[i_raddr];
        else                             r_rdata <= 8'h00;
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/frame_writer.sv
// Sinks the filtered interior pixel stream into the frame buffer, then paints the border.
module frame_writer #(
    parameter int         IMG_W      = img_pkg::IMG_W,
    parameter int         IMG_H      = img_pkg::IMG_H,
    parameter int         ADDR_W     = img_pkg::ADDR_W,
    parameter logic [7:0] BORDER_VAL = 8'h00
) (
    input  logic          clk,
    input  logic          rst_n,
    frame_writer_if.slave bus
);
    import img_pkg::*;

    localparam int                FRAME       = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] L_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] L_W         = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] L_COL_LAST  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] L_ROW_LAST  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] L_TOP_LAST  = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] L_BOT_FIRST = ADDR_W'((IMG_H - 1) * IMG_W);
    localparam logic [ADDR_W-1:0] L_BOT_LAST  = ADDR_W'(FRAME - 1);
    localparam logic [ADDR_W-1:0] L_SIDE_LAST = ADDR_W'((IMG_H - 1) * IMG_W - 1);

    state_t            r_state, w_next;
    border_ph_t        r_bph;
    logic [ADDR_W-1:0] r_row, r_col, r_base, r_wr_count, r_baddr;
    logic              w_start_ok, w_xfer, w_last_pix, w_border_last;
    logic              w_in_ready, w_busy, w_done, w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata, w_rd_data;

    assign w_start_ok    = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_xfer        = (r_state == ACCEPT) && bus.in_valid;
    assign w_last_pix    = w_xfer && (r_col == L_COL_LAST) && (r_row == L_ROW_LAST);
    assign w_border_last = (r_state == BORDER) && (r_bph == B_RIGHT) && (r_baddr == L_SIDE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (bus.start)     w_next = ACCEPT;
            ACCEPT:     if (w_last_pix)    w_next = BORDER;
            BORDER:     if (w_border_last) w_next = DONE;
            default:                       w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ACCEPT:  begin w_in_ready = 1'b1; w_busy = 1'b1; end
            BORDER:  w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Row base advances by IMG_W on each row wrap, so the write address is base + col.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_col      <= '0;
            r_base     <= '0;
            r_wr_count <= '0;
            r_baddr    <= '0;
            r_bph      <= B_TOP;
        end else if (w_start_ok) begin
            r_row      <= L_ONE;
            r_col      <= L_ONE;
            r_base     <= L_W;
            r_wr_count <= '0;
            r_baddr    <= '0;
            r_bph      <= B_TOP;
        end else if (w_xfer) begin
            r_wr_count <= r_wr_count + L_ONE;
            if (r_col == L_COL_LAST) begin
                r_col  <= L_ONE;
                r_row  <= r_row + L_ONE;
                r_base <= r_base + L_W;
            end else begin
                r_col  <= r_col + L_ONE;
            end
        end else if (r_state == BORDER) begin
            case (r_bph)
                B_TOP: begin
                    if (r_baddr == L_TOP_LAST) begin
                        r_baddr <= L_BOT_FIRST;
                        r_bph   <= B_BOT;
                    end else begin
                        r_baddr <= r_baddr + L_ONE;
                    end
                end
                B_BOT: begin
                    if (r_baddr == L_BOT_LAST) begin
                        r_baddr <= L_W;
                        r_bph   <= B_LEFT;
                    end else begin
                        r_baddr <= r_baddr + L_ONE;
                    end
                end
                // Right edge of row r is the left edge plus IMG_W-1; next left edge is one further.
                B_LEFT: begin
                    r_baddr <= r_baddr + L_W - L_ONE;
                    r_bph   <= B_RIGHT;
                end
                default: begin
                    r_baddr <= r_baddr + L_ONE;
                    r_bph   <= B_LEFT;
                end
            endcase
        end
    end

    assign w_we    = w_xfer || (r_state == BORDER);
    assign w_waddr = (r_state == BORDER) ? r_baddr : (r_base + r_col);
    assign w_wdata = (r_state == BORDER) ? BORDER_VAL : bus.in_pixel;

    frame_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (FRAME)
    ) u_ram (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_rd_data)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.wr_count = r_wr_count;
    assign bus.rd_data  = w_rd_data;
endmodule
